seletor_irrigacao: RTL and testbench

//  Sensor front end that feeds the irrigation display/timer controller. Synchronises and debounces the raw field

---
 rtl/seletor_irrigacao_pkg.sv | 45 ++++
 rtl/seletor_irrigacao_debounce_sync.sv | 50 +++++
 rtl/seletor_irrigacao.sv | 155 +++++++++++++++
 tb/tb_seletor_irrigacao.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seletor_irrigacao_pkg.sv
// Shared definitions for the irrigation sensor front end: FSM state codes,
// default timing constants, the debounced sensor bundle and the mode decode.
package seletor_pkg;

    // FSM state encoding; the values are shared with the downstream controller.
    localparam logic [1:0] OCIOSO = 2'b00;
    localparam logic [1:0] GOTEJ  = 2'b01;
    localparam logic [1:0] ASPER  = 2'b10;
    localparam logic [1:0] ERRO   = 2'b11;

    // Default timing at the production clock rate.
    localparam int DEB_CYCLES_DEF  = 50000;
    localparam int HOLD_CYCLES_DEF = 1000;
    localparam int CNT_W_DEF       = 17;

    // Debounced view of the field inputs.
    typedef struct packed {
        logic solo;
        logic ar;
        logic temp;
        logic nmin;
        logic nmax;
        logic botao_n;
    } sensores_t;

    // A full tank without the minimum-level sensor is physically impossible.
    function automatic logic falha_nivel(input sensores_t s);
        falha_nivel = s.nmax & ~s.nmin;
    endfunction

    // Irrigation mode wanted by the current sensor picture, ignoring faults.
    // Sprinklers only when soil, air and temperature all call for it.
    function automatic logic [1:0] modo_desejado(input sensores_t s);
        logic [1:0] modo;
        modo = OCIOSO;
        if (s.solo && s.nmin) begin
            if (s.temp && s.ar)
                modo = ASPER;
            else
                modo = GOTEJ;
        end
        modo_desejado = modo;
    endfunction

endpackage

// File: rtl/seletor_irrigacao_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// only follows the synchronised input after it has differed for DEB_CYCLES
// consecutive cycles; any return to the current level restarts the count.
module debounce_sync #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 17
) (
    input  logic clk1,
    input  logic reset_n,
    input  logic raw_in,
    input  logic rst_val,
    output logic level_out
);

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous field signal into clk1; reset to the idle level so
    // the first sample after reset does not look like an edge.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= rst_val;
            sync_b <= rst_val;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // Count consecutive cycles of disagreement; commit the new level on the
    // last one and start over.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            level_out <= rst_val;
        end else if (sync_b == level_out) begin
            cnt <= '0;
        end else if (cnt == CNT_TC) begin
            cnt       <= '0;
            level_out <= sync_b;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/seletor_irrigacao.sv
// Irrigation sensor front end. Cleans up the raw field sensors and the start
// button, picks the irrigation mode with a minimum dwell time, runs the tank
// fill valve with level hysteresis and flags inconsistent level sensors.
//
//  state  | meaning
//  OCIOSO | no irrigation requested
//  GOTEJ  | drip irrigation requested
//  ASPER  | sprinkler irrigation requested
//  ERRO   | level sensors disagree; everything off, alarm raised
module seletor_irrigacao
    import seletor_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk1,
    input  logic reset_n,
    input  logic solo_seco,
    input  logic ar_seco,
    input  logic temp_alta,
    input  logic nivel_min,
    input  logic nivel_max,
    input  logic botao_n,
    output logic Gotejamento,
    output logic Aspersao,
    output logic buttom,
    output logic valvula_enchim,
    output logic alarme
);

    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    sensores_t        deb;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       desejado;
    logic [CNT_W-1:0] hold_cnt;
    logic             falha;
    logic             hold_ok;
    logic             valvula_nxt;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_solo (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (solo_seco),
        .rst_val   (1'b0),
        .level_out (deb.solo)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_ar (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (ar_seco),
        .rst_val   (1'b0),
        .level_out (deb.ar)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_temp (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (temp_alta),
        .rst_val   (1'b0),
        .level_out (deb.temp)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_nmin (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (nivel_min),
        .rst_val   (1'b0),
        .level_out (deb.nmin)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_nmax (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (nivel_max),
        .rst_val   (1'b0),
        .level_out (deb.nmax)
    );

    // The button idles high (released), so its filter resets to 1.
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_botao (
        .clk1      (clk1),
        .reset_n   (reset_n),
        .raw_in    (botao_n),
        .rst_val   (1'b1),
        .level_out (deb.botao_n)
    );

    // The debounced button level is already a flop output; pass it straight on.
    assign buttom = deb.botao_n;

    // Mode selection: a sensor fault wins immediately, otherwise a mode change
    // waits until the current state has been held long enough. Losing the
    // minimum level is treated like any other mode change.
    always_comb begin
        falha     = falha_nivel(deb);
        desejado  = modo_desejado(deb);
        hold_ok   = (hold_cnt >= HOLD_TC);
        state_nxt = state;
        if (falha)
            state_nxt = ERRO;
        else if (state == ERRO)
            state_nxt = OCIOSO;
        else if ((desejado != state) && hold_ok)
            state_nxt = desejado;
    end

    // Fill valve: open below minimum, close at maximum, hold in between, and
    // always closed while the level sensors are inconsistent.
    always_comb begin
        valvula_nxt = valvula_enchim;
        if (state_nxt == ERRO)
            valvula_nxt = 1'b0;
        else if (!deb.nmin)
            valvula_nxt = 1'b1;
        else if (deb.nmax)
            valvula_nxt = 1'b0;
    end

    // State register and dwell counter; the counter restarts on every change
    // and parks at its terminal value.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= OCIOSO;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                hold_cnt <= '0;
            else if (!hold_ok)
                hold_cnt <= hold_cnt + HOLD_ONE;
        end
    end

    // Registered outputs decoded from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            Gotejamento    <= 1'b0;
            Aspersao       <= 1'b0;
            alarme         <= 1'b0;
            valvula_enchim <= 1'b0;
        end else begin
            Gotejamento    <= (state_nxt == GOTEJ);
            Aspersao       <= (state_nxt == ASPER);
            alarme         <= (state_nxt == ERRO);
            valvula_enchim <= valvula_nxt;
        end
    end

endmodule

// File: tb/tb_seletor_irrigacao.sv
// Directed bench for seletor_irrigacao with DEB_CYCLES=4, HOLD_CYCLES=8.
// The stimulus process queues the expected output changes (value and cycle)
// and state snapshots; the monitor compares them as the outputs move.
module tb_seletor_irrigacao;
    import seletor_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk1      = 1'b0;
    logic reset_n   = 1'b1;
    logic solo_seco = 1'b0;
    logic ar_seco   = 1'b0;
    logic temp_alta = 1'b0;
    logic nivel_min = 1'b0;
    logic nivel_max = 1'b0;
    logic botao_n   = 1'b1;
    logic Gotejamento;
    logic Aspersao;
    logic buttom;
    logic valvula_enchim;
    logic alarme;

    seletor_irrigacao #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (4)
    ) dut (
        .clk1           (clk1),
        .reset_n        (reset_n),
        .solo_seco      (solo_seco),
        .ar_seco        (ar_seco),
        .temp_alta      (temp_alta),
        .nivel_min      (nivel_min),
        .nivel_max      (nivel_max),
        .botao_n        (botao_n),
        .Gotejamento    (Gotejamento),
        .Aspersao       (Aspersao),
        .buttom         (buttom),
        .valvula_enchim (valvula_enchim),
        .alarme         (alarme)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // {Gotejamento, Aspersao, buttom, valvula_enchim, alarme}
    logic [4:0] outs;
    assign outs = {Gotejamento, Aspersao, buttom, valvula_enchim, alarme};

    typedef struct {
        logic [4:0] vec;
        int         cyc;
        string      tag;
    } ev_t;

    typedef struct {
        logic [4:0] vec;
        logic [1:0] st;
        string      tag;
    } snap_t;

    ev_t   ev_q[$];
    snap_t sn_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 1'b0;
    bit    first = 1'b1;
    logic [4:0] prev;

    function automatic void exp_ev(input logic [4:0] v, input int c, input string t);
        ev_q.push_back('{vec: v, cyc: c, tag: t});
    endfunction

    function automatic void exp_snap(input logic [4:0] v, input logic [1:0] s, input string t);
        sn_q.push_back('{vec: v, st: s, tag: t});
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk1);
            #1;
        end
    endtask

    // Monitor: every output change consumes the next expected change; pending
    // snapshots are compared on the negedge after they are queued.
    always @(negedge clk1) begin : mon
        logic [4:0] cur;
        ev_t        e;
        snap_t      s;
        cur = outs;
        if (first) begin
            first = 1'b0;
        end else if (cur !== prev) begin
            n_cmp++;
            if (ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: outputs %b at cycle %0d, required to stay %b", cur, cyc, prev);
            end else begin
                e = ev_q.pop_front();
                if (cur !== e.vec || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s: outputs %b at cycle %0d, required %b at cycle %0d",
                             e.tag, cur, cyc, e.vec, e.cyc);
                end
            end
        end
        prev = cur;
        if (sn_q.size() != 0) begin
            s = sn_q.pop_front();
            n_cmp++;
            if (cur !== s.vec || dut.state !== s.st) begin
                n_bad++;
                $display("FAIL %s: outputs %b state %b, required outputs %b state %b",
                         s.tag, cur, dut.state, s.vec, s.st);
            end
        end
        if (done) begin
            while (ev_q.size() != 0) begin
                e = ev_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: change never seen (outputs %b), required %b at cycle %0d",
                         e.tag, cur, e.vec, e.cyc);
            end
            while (sn_q.size() != 0) begin
                s = sn_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: snapshot never taken, required %b", s.tag, s.vec);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin : stim
        int rr, k, g, a, c5, c6, c8, c9, cb, cr;

        // 1. Reset with every sensor low and the button released.
        #2 reset_n = 1'b0;
        tick(3);
        exp_snap(5'b00100, OCIOSO, "reset_values");
        tick(2);
        rr = cyc;
        reset_n = 1'b1;
        exp_ev(5'b00110, rr + 1, "valve_opens_after_reset");
        tick(12);

        // Minimum level reached: valve holds open, no mode yet without dry soil.
        nivel_min = 1'b1;
        tick(10);

        // 2. Three-cycle glitch on the soil sensor must be filtered out.
        solo_seco = 1'b1;
        tick(3);
        solo_seco = 1'b0;
        tick(10);

        k = cyc;
        solo_seco = 1'b1;
        g = k + DEB + 3;
        exp_ev(5'b10110, g, "gotej_rise");

        // 3. Sprinkler conditions right after entering drip: held for the dwell time.
        wait_to(g);
        temp_alta = 1'b1;
        ar_seco   = 1'b1;
        a = g + HOLD;
        exp_ev(5'b01110, a, "asper_after_hold");

        // 4. Impossible level combination pre-empts the dwell time.
        wait_to(a);
        nivel_max = 1'b1;
        nivel_min = 1'b0;
        exp_ev(5'b00101, a + 7, "erro_entry");

        c5 = a + 12;
        wait_to(c5);
        nivel_min = 1'b1;
        exp_ev(5'b00100, c5 + 7, "erro_exit_to_ocioso");
        exp_ev(5'b01100, c5 + 7 + HOLD, "asper_reselect");

        // 5. Levels drop while the new mode is still young: valve reacts at
        //    once, the mode change waits for the dwell time.
        c6 = c5 + 7 + HOLD;
        wait_to(c6);
        nivel_max = 1'b0;
        nivel_min = 1'b0;
        solo_seco = 1'b0;
        exp_ev(5'b01110, c6 + 7, "valve_sets_low_level");
        exp_ev(5'b00110, c6 + 8, "asper_leaves_after_hold");

        c8 = c6 + 12;
        wait_to(c8);
        nivel_min = 1'b1;
        wait_to(c8 + 8);
        exp_snap(5'b00110, OCIOSO, "valve_holds_between_levels");

        c9 = c8 + 10;
        wait_to(c9);
        nivel_max = 1'b1;
        exp_ev(5'b00100, c9 + 7, "valve_clears_at_max");
        wait_to(c9 + 12);

        // 6. Button press with a two-cycle bounce at each end.
        cb = cyc;
        exp_ev(5'b00000, cb + 8, "button_fall");
        exp_ev(5'b00100, cb + 18, "button_rise_after_10");
        botao_n = 1'b0;
        tick(1);
        botao_n = 1'b1;
        tick(1);
        botao_n = 1'b0;
        tick(8);
        botao_n = 1'b1;
        tick(1);
        botao_n = 1'b0;
        tick(1);
        botao_n = 1'b1;
        wait_to(cb + 25);

        // Reset in the middle of a press forces the button output high at once.
        cr = cyc;
        botao_n = 1'b0;
        exp_ev(5'b00000, cr + 6, "button_fall_2");
        wait_to(cr + 8);
        exp_ev(5'b00100, cr + 8, "reset_forces_button_high");
        exp_snap(5'b00100, OCIOSO, "reset_mid_window");
        reset_n   = 1'b0;
        solo_seco = 1'b1;
        botao_n   = 1'b1;
        tick(3);

        // After reset every input must be re-debounced before a mode returns.
        rr = cyc;
        reset_n = 1'b1;
        exp_ev(5'b00110, rr + 1, "valve_opens_after_reset_2");
        exp_ev(5'b00100, rr + 7, "valve_clears_after_rebounce");
        exp_ev(5'b01100, rr + 8, "asper_reselected_after_reset");
        tick(15);

        done = 1'b1;
        tick(5);
    end

endmodule
